// File: rtl/cpu_clk_ctrl.sv
// CPU run-control: turns a free-running prescaler into a one-clk cpu_ce pulse.
// The pulse is scheduled by a HALT/RUN/STEP/BURST mode machine, and a
// retired-cycle counter tracks how many pulses have been issued.
module cpu_clk_ctrl #(
   parameter int DIV_FAST = 3,
   parameter int DIV_SLOW = 25,
   parameter int CNT_W    = 32,
   parameter int BL_W     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              run_sw,
   input  logic              slow_sw,
   input  logic              step,
   input  logic              burst_go,
   input  logic [BL_W-1:0]   burst_len,
   input  logic              halt_req,
   input  logic              clr_cnt,
   output logic              cpu_ce,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic [BL_W-1:0]   burst_left,
   output logic [1:0]        state,
   output logic              busy
);

   typedef enum logic [1:0] {
      S_HALT  = 2'b00,
      S_RUN   = 2'b01,
      S_STEP  = 2'b10,
      S_BURST = 2'b11
   } state_t;

   localparam logic [31:0] MASK_FAST = (32'd1 << DIV_FAST) - 32'd1;
   localparam logic [31:0] MASK_SLOW = (32'd1 << DIV_SLOW) - 32'd1;

   logic [31:0]     presc;
   logic [31:0]     mask;
   logic            slow_q;
   logic            step_q;
   logic            step_rise;
   logic            tick;
   state_t          st_q, st_d;
   logic            ce_d;
   logic [BL_W-1:0] bl_d;

   assign mask  = slow_q ? MASK_SLOW : MASK_FAST;
   assign tick  = (presc & mask) == mask;
   assign state = st_q;

   // A step held high for several cycles must only retire one CPU cycle,
   // so act on its rising edge only.
   assign step_rise = step & ~step_q;

   // Prescaler; restarts from zero when the registered rate select changes
   // so the first tick at the new rate is a full period away.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         presc  <= '0;
         slow_q <= 1'b0;
      end else begin
         slow_q <= slow_sw;
         if (slow_sw != slow_q) presc <= '0;
         else                   presc <= presc + 32'd1;
      end
   end

   // Next mode, next pulse and next burst count.
   always_comb begin
      st_d = st_q;
      ce_d = 1'b0;
      bl_d = burst_left;
      unique case (st_q)
         S_HALT: begin
            if (halt_req) begin
               st_d = S_HALT;
            end else if (run_sw) begin
               st_d = S_RUN;
            end else if (burst_go && burst_len != '0) begin
               st_d = S_BURST;
               bl_d = burst_len;
            end else if (step_rise) begin
               st_d = S_STEP;
               ce_d = 1'b1;
            end
         end
         S_STEP: begin
            st_d = S_HALT;
         end
         S_RUN: begin
            ce_d = tick & run_sw & ~halt_req;
            if (!run_sw || halt_req) st_d = S_HALT;
         end
         S_BURST: begin
            if (halt_req) begin
               st_d = S_HALT;
            end else if (tick) begin
               ce_d = 1'b1;
               bl_d = burst_left - BL_W'(1);
               if (burst_left == BL_W'(1)) st_d = S_HALT;
            end
         end
         default: st_d = S_HALT;
      endcase
   end

   // Mode register and registered outputs; busy tracks the mode on the same edge.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         st_q       <= S_HALT;
         cpu_ce     <= 1'b0;
         burst_left <= '0;
         busy       <= 1'b0;
         step_q     <= 1'b0;
      end else begin
         st_q       <= st_d;
         cpu_ce     <= ce_d;
         burst_left <= bl_d;
         busy       <= (st_d != S_HALT);
         step_q     <= step;
      end
   end

   // Retired-cycle counter; a clear beats a coincident pulse.
   always_ff @(posedge clk) begin
      if (!rst_n)      cycle_cnt <= '0;
      else if (clr_cnt) cycle_cnt <= '0;
      else if (cpu_ce)  cycle_cnt <= cycle_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: directed stimulus pushes hand-computed expected
// pulses and output snapshots into queues; a negedge monitor pops and compares.
module tb_cpu_clk_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        run_sw = 1'b0;
   logic        slow_sw = 1'b0;
   logic        step = 1'b0;
   logic        burst_go = 1'b0;
   logic [15:0] burst_len = 16'd0;
   logic        halt_req = 1'b0;
   logic        clr_cnt = 1'b0;
   logic        cpu_ce;
   logic [3:0]  cycle_cnt;
   logic [15:0] burst_left;
   logic [1:0]  state;
   logic        busy;

   cpu_clk_ctrl #(.DIV_FAST(3), .DIV_SLOW(5), .CNT_W(4), .BL_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .run_sw(run_sw), .slow_sw(slow_sw),
      .step(step), .burst_go(burst_go), .burst_len(burst_len),
      .halt_req(halt_req), .clr_cnt(clr_cnt), .cpu_ce(cpu_ce),
      .cycle_cnt(cycle_cnt), .burst_left(burst_left), .state(state), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          cyc;
      logic        ce;
      logic [1:0]  st;
      logic        busy;
      logic [3:0]  cnt;
      logic [15:0] bl;
   } exp_t;

   exp_t pq[$];   // expected cpu_ce pulses
   exp_t sq[$];   // expected output snapshots at given cycles
   exp_t pe, se;

   int tests = 0;
   int fails = 0;
   int cyc = 0;
   int R = 0;
   bit done = 1'b0;
   bit fin  = 1'b0;

   // Cycle index: value seen at a negedge equals the number of posedges so far.
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void push_pulse(input int c, input logic [1:0] st,
                                      input logic [3:0] cnt, input logic [15:0] bl);
      exp_t e;
      e.cyc = c; e.ce = 1'b1; e.st = st; e.busy = (st != 2'd0); e.cnt = cnt; e.bl = bl;
      pq.push_back(e);
   endfunction

   function automatic void push_snap(input int c, input logic ce, input logic [1:0] st,
                                     input logic [3:0] cnt, input logic [15:0] bl);
      exp_t e;
      e.cyc = c; e.ce = ce; e.st = st; e.busy = (st != 2'd0); e.cnt = cnt; e.bl = bl;
      sq.push_back(e);
   endfunction

   // Monitor: compares every pulse and every due snapshot against the queues.
   always @(negedge clk) begin
      if (cpu_ce === 1'b1) begin
         tests++;
         if (pq.size() == 0) begin
            fails++;
            $display("FAIL pulse_unexpected cyc=%0d st=%0d cnt=%0d bl=%0d", cyc, state, cycle_cnt, burst_left);
         end else begin
            pe = pq.pop_front();
            if (pe.cyc != cyc || state !== pe.st || busy !== pe.busy ||
                cycle_cnt !== pe.cnt || burst_left !== pe.bl) begin
               fails++;
               $display("FAIL pulse got cyc=%0d st=%0d busy=%0b cnt=%0d bl=%0d want cyc=%0d st=%0d busy=%0b cnt=%0d bl=%0d",
                        cyc, state, busy, cycle_cnt, burst_left, pe.cyc, pe.st, pe.busy, pe.cnt, pe.bl);
            end
         end
      end else if (pq.size() > 0 && pq[0].cyc <= cyc) begin
         pe = pq.pop_front();
         tests++;
         fails++;
         $display("FAIL pulse_missing got none at cyc=%0d want pulse at cyc=%0d", cyc, pe.cyc);
      end
      while (sq.size() > 0 && sq[0].cyc <= cyc) begin
         se = sq.pop_front();
         tests++;
         if (se.cyc != cyc || cpu_ce !== se.ce || state !== se.st || busy !== se.busy ||
             cycle_cnt !== se.cnt || burst_left !== se.bl) begin
            fails++;
            $display("FAIL snap cyc=%0d got ce=%0b st=%0d busy=%0b cnt=%0d bl=%0d want cyc=%0d ce=%0b st=%0d busy=%0b cnt=%0d bl=%0d",
                     cyc, cpu_ce, state, busy, cycle_cnt, burst_left, se.cyc, se.ce, se.st, se.busy, se.cnt, se.bl);
         end
      end
      if (done && !fin) begin
         tests++;
         if (pq.size() != 0 || sq.size() != 0) begin
            fails++;
            $display("FAIL leftover got pulses=%0d snaps=%0d want 0 0", pq.size(), sq.size());
         end
         fin = 1'b1;
      end
   end

   task automatic wait_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   // Called at a negedge; the following edge is a reset edge and R names it.
   task automatic do_reset();
      push_snap(cyc + 1, 1'b0, 2'd0, 4'd0, 16'd0);
      rst_n = 1'b0;
      @(negedge clk);
      R = cyc;
   endtask

   initial begin
      @(negedge clk);

      // 1: free-run fast from reset, 5 pulses every 8 clk, then stop
      do_reset();
      run_sw = 1'b1; slow_sw = 1'b0; rst_n = 1'b1;
      push_snap(R + 1, 1'b0, 2'd1, 4'd0, 16'd0);
      for (int j = 1; j <= 5; j++) push_pulse(R + 8 * j, 2'd1, 4'(j - 1), 16'd0);
      push_snap(R + 41, 1'b0, 2'd1, 4'd5, 16'd0);
      push_snap(R + 42, 1'b0, 2'd0, 4'd5, 16'd0);
      wait_to(R + 41); run_sw = 1'b0;
      wait_to(R + 50);

      // 2: single step with step held 4 cycles -> one pulse
      do_reset();
      step = 1'b1; rst_n = 1'b1;
      push_pulse(R + 1, 2'd2, 4'd0, 16'd0);
      push_snap(R + 1, 1'b1, 2'd2, 4'd0, 16'd0);
      push_snap(R + 2, 1'b0, 2'd0, 4'd1, 16'd0);
      push_snap(R + 5, 1'b0, 2'd0, 4'd1, 16'd0);
      wait_to(R + 4); step = 1'b0;
      wait_to(R + 8);

      // 3: slow burst of 4, then a zero-length burst that must be ignored
      do_reset();
      slow_sw = 1'b1; burst_len = 16'd4; burst_go = 1'b1; rst_n = 1'b1;
      push_snap(R + 1, 1'b0, 2'd3, 4'd0, 16'd4);
      push_pulse(R + 33,  2'd3, 4'd0, 16'd3);
      push_pulse(R + 65,  2'd3, 4'd1, 16'd2);
      push_pulse(R + 97,  2'd3, 4'd2, 16'd1);
      push_pulse(R + 129, 2'd0, 4'd3, 16'd0);
      push_snap(R + 130, 1'b0, 2'd0, 4'd4, 16'd0);
      push_snap(R + 131, 1'b0, 2'd0, 4'd4, 16'd0);
      push_snap(R + 170, 1'b0, 2'd0, 4'd4, 16'd0);
      wait_to(R + 1);   burst_go = 1'b0;
      wait_to(R + 130); burst_go = 1'b1; burst_len = 16'd0;
      wait_to(R + 131); burst_go = 1'b0;
      wait_to(R + 171);

      // 4a: fast burst of 5 aborted by halt_req after the 2nd pulse
      slow_sw = 1'b0;
      do_reset();
      burst_len = 16'd5; burst_go = 1'b1; rst_n = 1'b1;
      push_snap(R + 1, 1'b0, 2'd3, 4'd0, 16'd5);
      push_pulse(R + 8,  2'd3, 4'd0, 16'd4);
      push_pulse(R + 16, 2'd3, 4'd1, 16'd3);
      push_snap(R + 17, 1'b0, 2'd0, 4'd2, 16'd3);
      push_snap(R + 30, 1'b0, 2'd0, 4'd2, 16'd3);
      wait_to(R + 1);  burst_go = 1'b0;
      wait_to(R + 16); halt_req = 1'b1;
      wait_to(R + 17); halt_req = 1'b0;
      wait_to(R + 31);

      // 4b: halt_req coincident with the first tick -> no pulse at all
      do_reset();
      burst_len = 16'd5; burst_go = 1'b1; rst_n = 1'b1;
      push_snap(R + 1,  1'b0, 2'd3, 4'd0, 16'd5);
      push_snap(R + 8,  1'b0, 2'd0, 4'd0, 16'd5);
      push_snap(R + 20, 1'b0, 2'd0, 4'd0, 16'd5);
      wait_to(R + 1); burst_go = 1'b0;
      wait_to(R + 7); halt_req = 1'b1;
      wait_to(R + 8); halt_req = 1'b0;
      wait_to(R + 21);

      // 5: rate change mid-period restarts the period; reset on a tick cycle
      do_reset();
      run_sw = 1'b1; slow_sw = 1'b0; rst_n = 1'b1;
      push_pulse(R + 8,  2'd1, 4'd0, 16'd0);
      push_pulse(R + 16, 2'd1, 4'd1, 16'd0);
      push_snap(R + 20, 1'b0, 2'd1, 4'd2, 16'd0);
      push_pulse(R + 52, 2'd1, 4'd2, 16'd0);
      push_snap(R + 53, 1'b0, 2'd1, 4'd3, 16'd0);
      wait_to(R + 19); slow_sw = 1'b1;
      wait_to(R + 83);
      do_reset();

      // 6: counter wrap after 16 pulses, then clear coincident with a pulse
      slow_sw = 1'b0; run_sw = 1'b1; rst_n = 1'b1;
      for (int j = 1; j <= 16; j++) push_pulse(R + 8 * j, 2'd1, 4'(j - 1), 16'd0);
      push_snap(R + 129, 1'b0, 2'd1, 4'd0, 16'd0);
      push_pulse(R + 136, 2'd1, 4'd0, 16'd0);
      push_pulse(R + 144, 2'd1, 4'd1, 16'd0);
      push_pulse(R + 152, 2'd1, 4'd2, 16'd0);
      push_snap(R + 153, 1'b0, 2'd1, 4'd0, 16'd0);
      push_pulse(R + 160, 2'd1, 4'd0, 16'd0);
      push_snap(R + 161, 1'b0, 2'd0, 4'd1, 16'd0);
      push_snap(R + 170, 1'b0, 2'd0, 4'd1, 16'd0);
      wait_to(R + 152); clr_cnt = 1'b1;
      wait_to(R + 153); clr_cnt = 1'b0;
      wait_to(R + 160); run_sw = 1'b0;
      wait_to(R + 172);

      done = 1'b1;
      @(negedge clk);
      @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
